// File: rtl/dmem_arbiter.sv
// Purpose : arbitrates one single-port data memory between a CPU load/store port and a DMA port.
// Latency : uncontended request acked the cycle after it is first sampled; contended worst case two cycles.
// Backpres: requesters hold their request until ack; CPU is frozen via cpu_stall until its grant cycle.
module dmem_arbiter #(
    parameter int ADDR_W    = 7,
    parameter int DATA_W    = 32,
    parameter int BURST_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_stall,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_ack,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, GNT_CPU, GNT_DMA} state_t;

    localparam int          CW   = ($clog2(BURST_MAX + 1) > 0) ? $clog2(BURST_MAX + 1) : 1;
    localparam logic [CW-1:0] BMAX = CW'(BURST_MAX);
    localparam logic        LAST_CPU = 1'b0;
    localparam logic        LAST_DMA = 1'b1;

    state_t              state;
    state_t              nxt;
    logic                last_gnt;
    logic [CW-1:0]       dma_burst_cnt;
    logic [DATA_W-1:0]   cpu_rdata_q;
    logic [DATA_W-1:0]   dma_rdata_q;
    logic                cpu_act;
    logic                cpu_go;
    logic                dma_go;

    // a simultaneous rd+wr is a write, so only cpu_wr decides direction
    assign cpu_act = cpu_rd | cpu_wr;

    // an access only happens if the grantee still requests now; reset aborts any grant in flight
    assign cpu_go = (state == GNT_CPU) && cpu_act && !rst;
    assign dma_go = (state == GNT_DMA) && dma_req && !rst;

    assign cpu_ack   = cpu_go;
    assign dma_ack   = dma_go;
    assign cpu_stall = cpu_act && (state != GNT_CPU);

    // read data is passed straight through on a read grant, otherwise the last value is held
    assign cpu_rdata = (cpu_go && !cpu_wr) ? mem_rdata : cpu_rdata_q;
    assign dma_rdata = (dma_go && !dma_we) ? mem_rdata : dma_rdata_q;

    // steer the memory port from the granted requester's live inputs, quiet otherwise
    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (cpu_go) begin
            mem_read  = !cpu_wr;
            mem_write = cpu_wr;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (dma_go) begin
            mem_read  = !dma_we;
            mem_write = dma_we;
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
        end
    end

    // round-robin on contention; DMA may only take the turn while its run is under the cap
    always_comb begin
        nxt = IDLE;
        if (cpu_act && dma_req) begin
            if ((last_gnt == LAST_CPU) && (dma_burst_cnt < BMAX))
                nxt = GNT_DMA;
            else
                nxt = GNT_CPU;
        end else if (cpu_act) begin
            nxt = GNT_CPU;
        end else if (dma_req) begin
            nxt = GNT_DMA;
        end
    end

    // grant state, fairness history, DMA run length and held read data
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            last_gnt      <= LAST_DMA;
            dma_burst_cnt <= '0;
            cpu_rdata_q   <= '0;
            dma_rdata_q   <= '0;
        end else begin
            state <= nxt;
            case (nxt)
                GNT_CPU: begin
                    last_gnt      <= LAST_CPU;
                    dma_burst_cnt <= '0;
                end
                GNT_DMA: begin
                    last_gnt <= LAST_DMA;
                    if (dma_burst_cnt < BMAX)
                        dma_burst_cnt <= dma_burst_cnt + 1'b1;
                end
                default: dma_burst_cnt <= '0;
            endcase
            if (cpu_go && !cpu_wr)
                cpu_rdata_q <= mem_rdata;
            if (dma_go && !dma_we)
                dma_rdata_q <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Purpose : self-checking bench for dmem_arbiter: vector table, corner sequences, random traffic vs a rule model.
// Latency : checks are sampled on the falling edge of the cycle they describe.
// Backpres: bench requesters hold each request until they see its ack.
module tb_dmem_arbiter;

    localparam int ADDR_W    = 7;
    localparam int DATA_W    = 32;
    localparam int BURST_MAX = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              cpu_rd, cpu_wr, cpu_ack, cpu_stall;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
    logic              dma_req, dma_we, dma_ack;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_wdata, dma_rdata;
    logic              mem_read, mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_MAX(BURST_MAX)) dut (
        .clk(clk), .rst(rst),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_rdata(dma_rdata), .dma_ack(dma_ack),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(int i);
        return (i == 5) ? 32'hDEAD_BEEF : 32'hA000_0000 + i;
    endfunction

    // bench data memory: combinational read, written on the clock, refilled by reset
    logic [31:0] tbmem [128];
    assign mem_rdata = tbmem[mem_addr];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 128; i++) tbmem[i] <= init_word(i);
        end else if (mem_write) begin
            tbmem[mem_addr] <= mem_wdata;
        end
    end

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
        else pass_cnt++;
    endtask

    typedef struct {
        bit crd; bit cwr; int ca;
        bit dr;  bit dwe; int da;
        bit ec;  bit ed;  bit emr; bit emw; int ema; bit est;
    } vec_t;

    function automatic vec_t v(bit crd, bit cwr, int ca, bit dr, bit dwe, int da,
                               bit ec, bit ed, bit emr, bit emw, int ema, bit est);
        vec_t r;
        r.crd = crd; r.cwr = cwr; r.ca = ca; r.dr = dr; r.dwe = dwe; r.da = da;
        r.ec = ec; r.ed = ed; r.emr = emr; r.emw = emw; r.ema = ema; r.est = est;
        return r;
    endfunction

    task automatic idle_inputs();
        cpu_rd = 0; cpu_wr = 0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
    endtask

    vec_t tbl [25];
    int   alt_c, alt_d;

    // random-phase model state and requester bookkeeping
    int   m_last, m_run, g;
    bit   c_s, d_s, exp_c, exp_d, c_done, d_done;
    int   c_age, d_age;
    logic [31:0] ref_mem [128];

    initial begin
        // ---------------- reset state, CPU request held during reset
        idle_inputs();
        rst = 1; cpu_rd = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", 32'(cpu_stall), 1);
        chk("rst_cack", 32'(cpu_ack), 0);
        chk("rst_dack", 32'(dma_ack), 0);
        chk("rst_strobes", {30'd0, mem_read, mem_write}, 0);
        chk("rst_cpu_rdata", cpu_rdata, 0);
        chk("rst_dma_rdata", dma_rdata, 0);
        @(posedge clk); #1 rst = 0; cpu_rd = 0;

        // ---------------- vector table: contention start, 8-cycle alternation, DMA stream
        tbl[0] = v(0,1,2, 1,0,3, 0,0,0,0,0, 1);
        tbl[1] = v(0,1,2, 1,0,3, 1,0,0,1,2, 0);
        tbl[2] = v(0,0,0, 1,0,3, 0,1,1,0,3, 0);
        tbl[3] = v(0,0,0, 0,0,0, 0,0,0,0,0, 0);
        tbl[4] = v(0,0,0, 0,0,0, 0,0,0,0,0, 0);
        tbl[5] = v(1,0,4, 1,1,6, 0,0,0,0,0, 1);
        for (int i = 6; i <= 13; i++)
            tbl[i] = (i % 2 == 0) ? v(1,0,4, 1,1,6, 1,0,1,0,4, 0)
                                  : v(1,0,4, 1,1,6, 0,1,0,1,6, 1);
        tbl[14] = v(0,0,0, 0,0,0, 0,0,0,0,0, 0);
        tbl[15] = v(0,0,0, 0,0,0, 0,0,0,0,0, 0);
        tbl[16] = v(0,0,0, 1,1,8, 0,0,0,0,0, 0);
        for (int i = 17; i <= 22; i++)
            tbl[i] = v(0,0,0, 1,1,i-9, 0,1,0,1,i-9, 0);
        tbl[17].da = 8;
        tbl[17].ema = 8;
        tbl[23] = v(0,0,0, 0,0,0, 0,0,0,0,0, 0);
        tbl[24] = v(0,0,0, 0,0,0, 0,0,0,0,0, 0);

        alt_c = 0; alt_d = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            cpu_rd = tbl[i].crd; cpu_wr = tbl[i].cwr;
            cpu_addr = ADDR_W'(tbl[i].ca); cpu_wdata = 32'h11;
            dma_req = tbl[i].dr; dma_we = tbl[i].dwe;
            dma_addr = ADDR_W'(tbl[i].da); dma_wdata = 32'h100 + tbl[i].da;
            @(negedge clk);
            chk($sformatf("tbl%0d_cack", i), 32'(cpu_ack), 32'(tbl[i].ec));
            chk($sformatf("tbl%0d_dack", i), 32'(dma_ack), 32'(tbl[i].ed));
            chk($sformatf("tbl%0d_mrd", i), 32'(mem_read), 32'(tbl[i].emr));
            chk($sformatf("tbl%0d_mwr", i), 32'(mem_write), 32'(tbl[i].emw));
            chk($sformatf("tbl%0d_maddr", i), 32'(mem_addr), 32'(tbl[i].ema));
            chk($sformatf("tbl%0d_stall", i), 32'(cpu_stall), 32'(tbl[i].est));
            if (tbl[i].emw)
                chk($sformatf("tbl%0d_mwdata", i), mem_wdata,
                    tbl[i].ec ? 32'h11 : 32'h100 + tbl[i].da);
            if (i == 2 || i == 3)
                chk($sformatf("tbl%0d_dma_rdata", i), dma_rdata, 32'hA000_0003);
            if (i >= 6 && i <= 13) begin
                alt_c += int'(cpu_ack);
                alt_d += int'(dma_ack);
            end
        end
        chk("alt_cpu_acks", 32'(alt_c), 4);
        chk("alt_dma_acks", 32'(alt_d), 4);

        // ---------------- lone CPU load from 0x05
        @(posedge clk); #1 cpu_rd = 1; cpu_addr = 7'h05;
        @(negedge clk);
        chk("ld_req_stall", 32'(cpu_stall), 1);
        chk("ld_req_cack", 32'(cpu_ack), 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("ld_cack", 32'(cpu_ack), 1);
        chk("ld_rdata", cpu_rdata, 32'hDEAD_BEEF);
        chk("ld_mrd", 32'(mem_read), 1);
        chk("ld_maddr", 32'(mem_addr), 5);
        chk("ld_stall", 32'(cpu_stall), 0);
        @(posedge clk); #1 cpu_rd = 0;
        @(negedge clk);
        chk("ld_after_cack", 32'(cpu_ack), 0);
        chk("ld_after_stall", 32'(cpu_stall), 0);
        chk("ld_hold_rdata", cpu_rdata, 32'hDEAD_BEEF);

        // ---------------- CPU store withdrawn in its grant cycle
        @(posedge clk); #1 cpu_wr = 1; cpu_addr = 7'h20; cpu_wdata = 32'h55;
        @(posedge clk); #1 cpu_wr = 0;
        @(negedge clk);
        chk("wd_cack", 32'(cpu_ack), 0);
        chk("wd_strobes", {30'd0, mem_read, mem_write}, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("wd_idle_strobes", {30'd0, mem_read, mem_write}, 0);
        chk("wd_idle_maddr", 32'(mem_addr), 0);

        // ---------------- reset pulse during a DMA grant with a CPU load pending
        @(posedge clk); #1 dma_req = 1; dma_we = 0; dma_addr = 7'h07;
        @(posedge clk); #1 rst = 1; cpu_rd = 1; cpu_addr = 7'h09;
        @(negedge clk);
        chk("rg_dack_in_rst", 32'(dma_ack), 0);
        chk("rg_strobes_in_rst", {30'd0, mem_read, mem_write}, 0);
        chk("rg_stall_in_rst", 32'(cpu_stall), 1);
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        chk("rg_dack_after", 32'(dma_ack), 0);
        chk("rg_cack_after", 32'(cpu_ack), 0);
        chk("rg_dma_rdata", dma_rdata, 0);
        chk("rg_cpu_rdata", cpu_rdata, 0);
        chk("rg_stall_after", 32'(cpu_stall), 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rg_cpu_first", 32'(cpu_ack), 1);
        chk("rg_dma_not_first", 32'(dma_ack), 0);
        chk("rg_cpu_addr", 32'(mem_addr), 9);
        chk("rg_cpu_data", cpu_rdata, 32'hA000_0009);
        @(posedge clk); #1 cpu_rd = 0;
        @(negedge clk);
        chk("rg_dma_second", 32'(dma_ack), 1);
        chk("rg_dma_data", dma_rdata, 32'hA000_0007);
        @(posedge clk); #1 idle_inputs();

        // ---------------- randomized traffic against the arbitration rules
        rst = 1;
        @(posedge clk); #1 rst = 0;
        for (int i = 0; i < 128; i++) ref_mem[i] = init_word(i);
        m_last = 1; m_run = 0; c_done = 0; d_done = 0; c_age = 0; d_age = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(posedge clk);
            c_s = cpu_rd | cpu_wr;
            d_s = dma_req;
            // whoever did not win last time goes next; DMA runs are capped
            if (c_s && d_s) g = (m_last == 1 || m_run >= BURST_MAX) ? 1 : 2;
            else if (c_s)   g = 1;
            else if (d_s)   g = 2;
            else            g = 0;
            if (g == 1) m_last = 0;
            if (g == 2) m_last = 1;
            m_run = (g == 2) ? ((m_run < BURST_MAX) ? m_run + 1 : BURST_MAX) : 0;
            #1;
            if (c_done || !(cpu_rd | cpu_wr)) begin
                cpu_rd = 0; cpu_wr = 0; c_age = 0;
                if ($urandom_range(0, 2) != 0) begin
                    cpu_rd = 1'($urandom_range(0, 1));
                    cpu_wr = !cpu_rd || ($urandom_range(0, 7) == 0);
                    cpu_addr = ADDR_W'($urandom_range(0, 15));
                    cpu_wdata = $urandom;
                end
            end
            if (d_done || !dma_req) begin
                dma_req = 0; d_age = 0;
                if ($urandom_range(0, 2) != 0) begin
                    dma_req = 1;
                    dma_we = 1'($urandom_range(0, 1));
                    dma_addr = ADDR_W'($urandom_range(0, 15));
                    dma_wdata = $urandom;
                end
            end
            @(negedge clk);
            exp_c = (g == 1) && (cpu_rd || cpu_wr);
            exp_d = (g == 2) && dma_req;
            chk("rnd_cack", 32'(cpu_ack), 32'(exp_c));
            chk("rnd_dack", 32'(dma_ack), 32'(exp_d));
            chk("rnd_stall", 32'(cpu_stall), 32'((cpu_rd || cpu_wr) && g != 1));
            chk("rnd_mrd", 32'(mem_read), 32'((exp_c && !cpu_wr) || (exp_d && !dma_we)));
            chk("rnd_mwr", 32'(mem_write), 32'((exp_c && cpu_wr) || (exp_d && dma_we)));
            if (exp_c) begin
                chk("rnd_c_maddr", 32'(mem_addr), 32'(cpu_addr));
                chk("rnd_c_latency", 32'(c_age <= 2), 1);
                if (cpu_wr) begin
                    chk("rnd_c_wdata", mem_wdata, cpu_wdata);
                    ref_mem[cpu_addr] = cpu_wdata;
                end else begin
                    chk("rnd_c_rdata", cpu_rdata, ref_mem[cpu_addr]);
                end
            end else if (exp_d) begin
                chk("rnd_d_maddr", 32'(mem_addr), 32'(dma_addr));
                chk("rnd_d_latency", 32'(d_age <= 2), 1);
                if (dma_we) begin
                    chk("rnd_d_wdata", mem_wdata, dma_wdata);
                    ref_mem[dma_addr] = dma_wdata;
                end else begin
                    chk("rnd_d_rdata", dma_rdata, ref_mem[dma_addr]);
                end
            end else if (g == 0) begin
                chk("rnd_idle_maddr", 32'(mem_addr), 0);
            end
            c_done = exp_c;
            d_done = exp_d;
            if ((cpu_rd || cpu_wr) && !exp_c) c_age++;
            if (dma_req && !exp_d) d_age++;
        end

        @(posedge clk); #1 idle_inputs();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
